// File: rtl/cdiv_pkg.sv
// Types and width helpers for the sequential complex divider.
package cdiv_pkg;

   typedef logic [1:0] cdiv_state_t;

   localparam cdiv_state_t ST_IDLE = 2'd0;
   localparam cdiv_state_t ST_PREP = 2'd1;
   localparam cdiv_state_t ST_DIV  = 2'd2;
   localparam cdiv_state_t ST_DONE = 2'd3;

   // Signed numerator of A*conj(B) needs one bit above the product width.
   function automatic int cdiv_num_w(input int dw);
      return 2 * dw + 1;
   endfunction

   // |B|^2 and numerator magnitudes peak at exactly 2^(2W-1), so 2W bits suffice.
   function automatic int cdiv_den_w(input int dw);
      return 2 * dw;
   endfunction

   function automatic int cdiv_cnt_w(input int dw);
      return $clog2(2 * dw);
   endfunction

   localparam int CDIV_DATA_WIDTH = 8;
   localparam int CDIV_ITER       = 2 * CDIV_DATA_WIDTH;
   localparam int CDIV_NUM_W      = cdiv_num_w(CDIV_DATA_WIDTH);
   localparam int CDIV_DEN_W      = cdiv_den_w(CDIV_DATA_WIDTH);
   localparam int CDIV_CNT_W      = cdiv_cnt_w(CDIV_DATA_WIDTH);

endpackage

// File: rtl/sat_pkg.sv
// Shared saturation helpers for the FFT datapath. All saturation is symmetric:
// the most negative code of the target width is never produced.
package sat_pkg;

   localparam int SAT_MAX_W = 64;

   // 9->8 saturator used after the FFT butterflies.
   function automatic logic signed [7:0] sat_9to8(input logic signed [8:0] x);
      if (x > 9'sd127) begin
         return 8'sd127;
      end
      if (x < -9'sd127) begin
         return -8'sd127;
      end
      return x[7:0];
   endfunction

   // Generic saturation of any value up to SAT_MAX_W bits to +/-(2^(w-1)-1).
   // Callers sign-extend into SAT_MAX_W and truncate the result to w bits.
   function automatic logic signed [SAT_MAX_W-1:0] sat_sym(
      input logic signed [SAT_MAX_W-1:0] x,
      input int                          w
   );
      logic signed [SAT_MAX_W-1:0] lim;
      lim = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
      if (x > lim) begin
         return lim;
      end
      if (x < -lim) begin
         return -lim;
      end
      return x;
   endfunction

endpackage

// File: rtl/cdiv_udiv_step.sv
// One restoring-division iteration: shift the next numerator bit into the
// remainder, subtract the divisor if it fits, shift the quotient bit in.
module udiv_step #(
   parameter int MAG_W = 16
) (
   input  logic [MAG_W-1:0] rem_i,
   input  logic [MAG_W-1:0] quo_i,
   input  logic [MAG_W-1:0] den_i,
   output logic [MAG_W-1:0] rem_o,
   output logic [MAG_W-1:0] quo_o
);

   logic [MAG_W:0] trial;
   logic [MAG_W:0] den_x;

   // The quotient register doubles as the numerator shift register.
   always_comb begin
      trial = {rem_i, quo_i[MAG_W-1]};
      den_x = {1'b0, den_i};
      if (trial >= den_x) begin
         rem_o = MAG_W'(trial - den_x);
         quo_o = {quo_i[MAG_W-2:0], 1'b1};
      end else begin
         rem_o = trial[MAG_W-1:0];
         quo_o = {quo_i[MAG_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/cdiv.sv
// Sequential complex divider Y = A/B = A*conj(B)/|B|^2, both components in
// parallel, one quotient bit per cycle, symmetric saturation on the result.
//
// state   | meaning
// IDLE    | ready for operands, last result held on Y
// PREP    | form numerators and |B|^2, catch divide-by-zero
// DIV     | ITER restoring iterations, counter counts down to 0
// DONE    | result valid, held until out_ready
module cdiv
   import sat_pkg::*;
   import cdiv_pkg::*;
#(
   parameter int DATA_WIDTH = CDIV_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] A_real,
   input  logic signed [DATA_WIDTH-1:0] A_imag,
   input  logic signed [DATA_WIDTH-1:0] B_real,
   input  logic signed [DATA_WIDTH-1:0] B_imag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] Y_real,
   output logic signed [DATA_WIDTH-1:0] Y_imag,
   output logic                         div_zero
);

   localparam int ITER  = 2 * DATA_WIDTH;
   localparam int NUM_W = cdiv_num_w(DATA_WIDTH);
   localparam int MAG_W = cdiv_den_w(DATA_WIDTH);
   localparam int CNT_W = cdiv_cnt_w(DATA_WIDTH);

   cdiv_state_t                  state_q, state_d;
   logic signed [DATA_WIDTH-1:0] a_r_q, a_r_d, a_i_q, a_i_d;
   logic signed [DATA_WIDTH-1:0] b_r_q, b_r_d, b_i_q, b_i_d;
   logic [MAG_W-1:0]             den_q, den_d;
   logic [MAG_W-1:0]             rem_r_q, rem_r_d, rem_i_q, rem_i_d;
   logic [MAG_W-1:0]             quo_r_q, quo_r_d, quo_i_q, quo_i_d;
   logic                         neg_r_q, neg_r_d, neg_i_q, neg_i_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic signed [DATA_WIDTH-1:0] y_r_q, y_r_d, y_i_q, y_i_d;
   logic                         dz_q, dz_d;

   logic signed [NUM_W-1:0]      ar_x, ai_x, br_x, bi_x;
   logic signed [NUM_W-1:0]      nr_c, ni_c;
   logic [MAG_W-1:0]             nr_mag, ni_mag, den_c;
   logic [MAG_W-1:0]             rem_r_nxt, rem_i_nxt, quo_r_nxt, quo_i_nxt;
   logic signed [SAT_MAX_W-1:0]  qs_r, qs_i;
   logic signed [DATA_WIDTH-1:0] y_r_fin, y_i_fin;

   always_comb begin
      ar_x   = NUM_W'(a_r_q);
      ai_x   = NUM_W'(a_i_q);
      br_x   = NUM_W'(b_r_q);
      bi_x   = NUM_W'(b_i_q);
      nr_c   = ar_x * br_x + ai_x * bi_x;
      ni_c   = ai_x * br_x - ar_x * bi_x;
      den_c  = MAG_W'(br_x * br_x + bi_x * bi_x);
      nr_mag = MAG_W'(nr_c[NUM_W-1] ? -nr_c : nr_c);
      ni_mag = MAG_W'(ni_c[NUM_W-1] ? -ni_c : ni_c);
   end

   udiv_step #(.MAG_W(MAG_W)) u_step_r (
      .rem_i (rem_r_q),
      .quo_i (quo_r_q),
      .den_i (den_q),
      .rem_o (rem_r_nxt),
      .quo_o (quo_r_nxt)
   );

   udiv_step #(.MAG_W(MAG_W)) u_step_i (
      .rem_i (rem_i_q),
      .quo_i (quo_i_q),
      .den_i (den_q),
      .rem_o (rem_i_nxt),
      .quo_o (quo_i_nxt)
   );

   // Sign is reapplied to the magnitude quotient, which gives truncation toward zero.
   always_comb begin
      qs_r    = neg_r_q ? -$signed(SAT_MAX_W'(quo_r_nxt)) : $signed(SAT_MAX_W'(quo_r_nxt));
      qs_i    = neg_i_q ? -$signed(SAT_MAX_W'(quo_i_nxt)) : $signed(SAT_MAX_W'(quo_i_nxt));
      y_r_fin = DATA_WIDTH'(sat_sym(qs_r, DATA_WIDTH));
      y_i_fin = DATA_WIDTH'(sat_sym(qs_i, DATA_WIDTH));
   end

   always_comb begin
      state_d = state_q;
      a_r_d   = a_r_q;
      a_i_d   = a_i_q;
      b_r_d   = b_r_q;
      b_i_d   = b_i_q;
      den_d   = den_q;
      rem_r_d = rem_r_q;
      rem_i_d = rem_i_q;
      quo_r_d = quo_r_q;
      quo_i_d = quo_i_q;
      neg_r_d = neg_r_q;
      neg_i_d = neg_i_q;
      cnt_d   = cnt_q;
      y_r_d   = y_r_q;
      y_i_d   = y_i_q;
      dz_d    = dz_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_r_d   = A_real;
               a_i_d   = A_imag;
               b_r_d   = B_real;
               b_i_d   = B_imag;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            if (den_c == '0) begin
               dz_d    = 1'b1;
               y_r_d   = '0;
               y_i_d   = '0;
               state_d = ST_DONE;
            end else begin
               dz_d    = 1'b0;
               den_d   = den_c;
               rem_r_d = '0;
               rem_i_d = '0;
               quo_r_d = nr_mag;
               quo_i_d = ni_mag;
               neg_r_d = nr_c[NUM_W-1];
               neg_i_d = ni_c[NUM_W-1];
               cnt_d   = CNT_W'(ITER - 1);
               state_d = ST_DIV;
            end
         end
         ST_DIV: begin
            rem_r_d = rem_r_nxt;
            rem_i_d = rem_i_nxt;
            quo_r_d = quo_r_nxt;
            quo_i_d = quo_i_nxt;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               y_r_d   = y_r_fin;
               y_i_d   = y_i_fin;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_r_q   <= '0;
         a_i_q   <= '0;
         b_r_q   <= '0;
         b_i_q   <= '0;
         den_q   <= '0;
         rem_r_q <= '0;
         rem_i_q <= '0;
         quo_r_q <= '0;
         quo_i_q <= '0;
         neg_r_q <= 1'b0;
         neg_i_q <= 1'b0;
         cnt_q   <= '0;
         y_r_q   <= '0;
         y_i_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_r_q   <= a_r_d;
         a_i_q   <= a_i_d;
         b_r_q   <= b_r_d;
         b_i_q   <= b_i_d;
         den_q   <= den_d;
         rem_r_q <= rem_r_d;
         rem_i_q <= rem_i_d;
         quo_r_q <= quo_r_d;
         quo_i_q <= quo_i_d;
         neg_r_q <= neg_r_d;
         neg_i_q <= neg_i_d;
         cnt_q   <= cnt_d;
         y_r_q   <= y_r_d;
         y_i_q   <= y_i_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign Y_real    = y_r_q;
   assign Y_imag    = y_i_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_cdiv.sv
// Directed and randomised checks of the sequential complex divider.
module tb_cdiv;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] a_r, a_i, b_r, b_i;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] y_r, y_i;
   logic              div_zero;

   int total;
   int bad;

   cdiv #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A_real    (a_r),
      .A_imag    (a_i),
      .B_real    (b_r),
      .B_imag    (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y_real    (y_r),
      .Y_imag    (y_i),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operand pair and count edges until out_valid; drive-only.
   task automatic issue(input int ar, input int ai, input int br, input int bi,
                        output int lat, output bit rdy_low);
      @(posedge clk);
      #1;
      a_r      = 8'(ar);
      a_i      = 8'(ai);
      b_r      = 8'(br);
      b_i      = 8'(bi);
      in_valid = 1'b1;
      lat      = 0;
      rdy_low  = 1'b1;
      while (lat < 60) begin
         @(posedge clk);
         lat++;
         #1;
         in_valid = 1'b0;
         if (out_valid) break;
         if (in_ready) rdy_low = 1'b0;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   function automatic void model(input int ar, input int ai, input int br, input int bi,
                                 output int yr, output int yi, output bit dz);
      int nr, ni, den, qr, qi;
      nr  = ar * br + ai * bi;
      ni  = ai * br - ar * bi;
      den = br * br + bi * bi;
      if (den == 0) begin
         yr = 0;
         yi = 0;
         dz = 1'b1;
      end else begin
         qr = nr / den;
         qi = ni / den;
         yr = (qr > 127) ? 127 : ((qr < -127) ? -127 : qr);
         yi = (qi > 127) ? 127 : ((qi < -127) ? -127 : qi);
         dz = 1'b0;
      end
   endfunction

   task automatic test_reset();
      #12;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++;
      if (y_r !== 8'sd0 || y_i !== 8'sd0) begin
         bad++; $display("FAIL reset_y got=(%0d,%0d) want=(0,0)", y_r, y_i);
      end
      total++;
      if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got=%b want=0", div_zero); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      bit rdy_low;
      issue(6, 8, 3, 4, lat, rdy_low);
      total++;
      if (lat !== 18) begin bad++; $display("FAIL basic_latency got=%0d want=18", lat); end
      total++;
      if (rdy_low !== 1'b1) begin bad++; $display("FAIL basic_in_ready_busy got=high want=low"); end
      total++;
      if (int'(y_r) !== 2 || int'(y_i) !== 0) begin
         bad++; $display("FAIL basic_y got=(%0d,%0d) want=(2,0)", y_r, y_i);
      end
      total++;
      if (div_zero !== 1'b0) begin bad++; $display("FAIL basic_div_zero got=%b want=0", div_zero); end
      release_result();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL basic_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_trunc_sat();
      int lat;
      bit rdy_low;
      issue(7, -7, 2, 0, lat, rdy_low);
      total++;
      if (int'(y_r) !== 3 || int'(y_i) !== -3) begin
         bad++; $display("FAIL trunc_y got=(%0d,%0d) want=(3,-3)", y_r, y_i);
      end
      release_result();
      issue(-128, 0, 1, 0, lat, rdy_low);
      total++;
      if (int'(y_r) !== -127 || int'(y_i) !== 0) begin
         bad++; $display("FAIL sat_y got=(%0d,%0d) want=(-127,0)", y_r, y_i);
      end
      release_result();
   endtask

   task automatic test_div_zero();
      int lat;
      bit rdy_low;
      issue(100, -50, 0, 0, lat, rdy_low);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL dz_latency got=%0d want=2", lat); end
      total++;
      if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_zero); end
      total++;
      if (y_r !== 8'sd0 || y_i !== 8'sd0) begin
         bad++; $display("FAIL dz_y got=(%0d,%0d) want=(0,0)", y_r, y_i);
      end
      release_result();
   endtask

   task automatic test_back_pressure();
      int lat;
      bit rdy_low;
      issue(10, 10, 0, 5, lat, rdy_low);
      total++;
      if (int'(y_r) !== 2 || int'(y_i) !== -2 || lat !== 18) begin
         bad++; $display("FAIL bp_y got=(%0d,%0d) lat=%0d want=(2,-2) lat=18", y_r, y_i, lat);
      end
      a_r      = 8'sd1;
      a_i      = 8'sd1;
      b_r      = 8'sd1;
      b_i      = 8'sd0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(y_r) !== 2 || int'(y_i) !== -2) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got out_valid=%b in_ready=%b y=(%0d,%0d) want 1/0 (2,-2)",
                     k, out_valid, in_ready, y_r, y_i);
         end
      end
      in_valid = 1'b0;
      release_result();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || int'(y_r) !== 2 || int'(y_i) !== -2) begin
         bad++;
         $display("FAIL bp_release got out_valid=%b in_ready=%b y=(%0d,%0d) want 0/1 (2,-2)",
                  out_valid, in_ready, y_r, y_i);
      end
   endtask

   task automatic test_reset_mid_div();
      int lat;
      bit rdy_low;
      @(posedge clk);
      #1;
      a_r      = 8'sd6;
      a_i      = 8'sd8;
      b_r      = 8'sd3;
      b_i      = 8'sd4;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || y_r !== 8'sd0 || y_i !== 8'sd0 || div_zero !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_async got out_valid=%b y=(%0d,%0d) dz=%b want 0 (0,0) 0",
                  out_valid, y_r, y_i, div_zero);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
      issue(6, 8, 3, 4, lat, rdy_low);
      total++;
      if (int'(y_r) !== 2 || int'(y_i) !== 0 || lat !== 18) begin
         bad++; $display("FAIL rst_mid_next got=(%0d,%0d) lat=%0d want=(2,0) lat=18", y_r, y_i, lat);
      end
      release_result();
   endtask

   task automatic test_random();
      int ops [6][4] = '{'{-128, -128, -128, -128}, '{127, -128, -128, -128},
                         '{-128, -128, 1, 0}, '{-128, 5, 0, 1},
                         '{127, 127, -1, 0}, '{-5, 3, -128, 127}};
      int ar, ai, br, bi, er, ei, lat;
      bit edz, rdy_low;
      for (int n = 0; n < 1500; n++) begin
         if (n < 6) begin
            ar = ops[n][0]; ai = ops[n][1]; br = ops[n][2]; bi = ops[n][3];
         end else begin
            ar = int'($urandom_range(255)) - 128;
            ai = int'($urandom_range(255)) - 128;
            if ($urandom_range(1) == 0) begin
               br = int'($urandom_range(6)) - 3;
               bi = int'($urandom_range(6)) - 3;
            end else begin
               br = int'($urandom_range(255)) - 128;
               bi = int'($urandom_range(255)) - 128;
            end
         end
         model(ar, ai, br, bi, er, ei, edz);
         issue(ar, ai, br, bi, lat, rdy_low);
         total++;
         if (int'(y_r) !== er || int'(y_i) !== ei || div_zero !== edz || lat !== (edz ? 2 : 18)) begin
            bad++;
            $display("FAIL rand A=(%0d,%0d) B=(%0d,%0d) got=(%0d,%0d) dz=%b lat=%0d want=(%0d,%0d) dz=%b",
                     ar, ai, br, bi, y_r, y_i, div_zero, lat, er, ei, edz);
         end
         release_result();
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_r       = '0;
      a_i       = '0;
      b_r       = '0;
      b_i       = '0;
      test_reset();
      test_basic();
      test_trunc_sat();
      test_div_zero();
      test_back_pressure();
      test_reset_mid_div();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
